ex_muldiv: RTL and testbench

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/ex_muldiv_pkg.sv | 23 ++
 rtl/muldiv_core.sv | 58 +++++
 rtl/ex_muldiv.sv | 117 +++++++++++
 tb/tb_ex_muldiv.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared RV32 widths and M-extension funct3 encodings for the EX-stage multiply/divide unit.
package ex_muldiv_pkg;
  localparam int FUNCT3_WIDTH   = 3;
  localparam int RS_WIDTH       = 5;
  localparam int REG_DATA_WIDTH = 32;

  localparam logic [FUNCT3_WIDTH-1:0] F3_MUL    = 3'd0;
  localparam logic [FUNCT3_WIDTH-1:0] F3_MULH   = 3'd1;
  localparam logic [FUNCT3_WIDTH-1:0] F3_MULHSU = 3'd2;
  localparam logic [FUNCT3_WIDTH-1:0] F3_MULHU  = 3'd3;
  localparam logic [FUNCT3_WIDTH-1:0] F3_DIV    = 3'd4;
  localparam logic [FUNCT3_WIDTH-1:0] F3_DIVU   = 3'd5;
  localparam logic [FUNCT3_WIDTH-1:0] F3_REM    = 3'd6;
  localparam logic [FUNCT3_WIDTH-1:0] F3_REMU   = 3'd7;

  function automatic logic signed_a(input logic [FUNCT3_WIDTH-1:0] f);
    return (f == F3_MULH) || (f == F3_MULHSU) || (f == F3_DIV) || (f == F3_REM);
  endfunction

  function automatic logic signed_b(input logic [FUNCT3_WIDTH-1:0] f);
    return (f == F3_MULH) || (f == F3_DIV) || (f == F3_REM);
  endfunction
endpackage

// File: rtl/muldiv_core.sv
// Iterative unsigned datapath: radix-2 shift-add multiply / restoring divide, one bit per cycle.
module muldiv_core
  import ex_muldiv_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_i,
  input  logic                      step_i,
  input  logic                      is_div_i,
  input  logic [REG_DATA_WIDTH-1:0] a_i,
  input  logic [REG_DATA_WIDTH-1:0] b_i,
  output logic [REG_DATA_WIDTH-1:0] hi_o,
  output logic [REG_DATA_WIDTH-1:0] lo_o,
  output logic                      last_o
);
  logic [REG_DATA_WIDTH-1:0] hi_q, lo_q, b_q, hi_d, lo_d;
  logic                      div_q;
  logic [5:0]                cnt_q;
  logic [REG_DATA_WIDTH:0]   sum, shl, diff;

  // hi/lo form the 64-bit product (mul) or remainder/quotient pair (div).
  always_comb begin
    sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    shl  = {hi_q, lo_q[REG_DATA_WIDTH-1]};
    diff = shl - {1'b0, b_q};
    if (div_q) begin
      hi_d = diff[REG_DATA_WIDTH] ? shl[REG_DATA_WIDTH-1:0] : diff[REG_DATA_WIDTH-1:0];
      lo_d = {lo_q[REG_DATA_WIDTH-2:0], ~diff[REG_DATA_WIDTH]};
    end else begin
      hi_d = sum[REG_DATA_WIDTH:1];
      lo_d = {sum[0], lo_q[REG_DATA_WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else if (load_i) begin
      hi_q  <= '0;
      lo_q  <= a_i;
      b_q   <= b_i;
      div_q <= is_div_i;
      cnt_q <= '0;
    end else if (step_i) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      if (cnt_q != 6'd31) cnt_q <= cnt_q + 6'd1;
    end
  end

  assign hi_o   = hi_d;
  assign lo_o   = lo_d;
  assign last_o = (cnt_q == 6'd31);
endmodule

// File: rtl/ex_muldiv.sv
// RV32M EX-stage unit: FSM, operand sign stripping, result fix-up and divide fast paths.
module ex_muldiv
  import ex_muldiv_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      start,
  input  logic [FUNCT3_WIDTH-1:0]   funct3,
  input  logic [REG_DATA_WIDTH-1:0] rs1_data,
  input  logic [REG_DATA_WIDTH-1:0] rs2_data,
  input  logic [RS_WIDTH-1:0]       rd_in,
  output logic                      stall_req,
  output logic                      done,
  output logic [REG_DATA_WIDTH-1:0] result,
  output logic [RS_WIDTH-1:0]       rd_out
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e                    state_q, state_d;
  logic [FUNCT3_WIDTH-1:0]   op_q, op_d;
  logic                      neg_q, neg_d;
  logic [REG_DATA_WIDTH-1:0] result_q, result_d;
  logic [RS_WIDTH-1:0]       rd_q, rd_d;

  logic                      accept, sa, sb, is_div, div0, ovf, load, last;
  logic [REG_DATA_WIDTH-1:0] mag_a, mag_b, fast_res, hi, lo, quo, calc_res;
  logic [2*REG_DATA_WIDTH-1:0] prod;

  assign accept = (state_q == S_IDLE) && start && !flush;
  assign sa     = signed_a(funct3) && rs1_data[REG_DATA_WIDTH-1];
  assign sb     = signed_b(funct3) && rs2_data[REG_DATA_WIDTH-1];
  assign mag_a  = sa ? -rs1_data : rs1_data;
  assign mag_b  = sb ? -rs2_data : rs2_data;
  assign is_div = funct3[2];
  assign div0   = is_div && (rs2_data == '0);
  assign ovf    = is_div && !funct3[0] && (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF);
  // funct3[1] selects the remainder flavour of the divide ops.
  assign fast_res = div0 ? (funct3[1] ? rs1_data : 32'hFFFF_FFFF)
                         : (funct3[1] ? 32'h0 : 32'h8000_0000);

  muldiv_core u_core (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .step_i   (state_q == S_CALC),
    .is_div_i (is_div),
    .a_i      (mag_a),
    .b_i      (mag_b),
    .hi_o     (hi),
    .lo_o     (lo),
    .last_o   (last)
  );

  // hi/lo already include the final step, so the result is ready in the last CALC cycle.
  always_comb begin
    prod = neg_q ? (64'd0 - {hi, lo}) : {hi, lo};
    quo  = op_q[1] ? hi : lo;
    if (op_q[2])               calc_res = neg_q ? -quo : quo;
    else if (op_q == F3_MUL)   calc_res = prod[REG_DATA_WIDTH-1:0];
    else                       calc_res = prod[2*REG_DATA_WIDTH-1:REG_DATA_WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_q;
    rd_d     = rd_q;
    load     = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        op_d  = funct3;
        neg_d = (is_div && funct3[1]) ? sa : (sa ^ sb);
        rd_d  = rd_in;
        if (div0 || ovf) begin
          state_d  = S_DONE;
          result_d = fast_res;
        end else begin
          state_d = S_CALC;
          load    = 1'b1;
        end
      end
      S_CALC: if (last) begin
        state_d  = S_DONE;
        result_d = calc_res;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      rd_q     <= rd_d;
    end
  end

  assign stall_req = !rst && (accept || (state_q == S_CALC));
  assign done      = !rst && !flush && (state_q == S_DONE);
  assign result    = result_q;
  assign rd_out    = rd_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: directed literal cases plus randomized traffic against a transaction-level model.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_in;
  logic        stall_req, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ex_muldiv dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in),
    .stall_req(stall_req), .done(done), .result(result), .rd_out(rd_out)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, expv, $time);
    end
  endtask

  // Reference arithmetic straight from the RV32M definitions.
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      3'd0: begin up = ua * ub; return up[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        up = ua / ub; return up[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        up = ua % ub; return up[31:0];
      end
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Model: an op is either in flight with a cycle countdown, or its done cycle is pending.
  bit          m_busy = 1'b0, m_done = 1'b0;
  int          m_left = 0;
  logic [31:0] m_pend = '0, m_res = '0;
  logic [4:0]  m_rd = '0;

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("m_done",   32'(done),      32'(m_done && !rst && !flush));
      chk("m_stall",  32'(stall_req), 32'(!rst && (m_busy || (!m_done && start && !flush))));
      chk("m_result", result,         m_res);
      chk("m_rd",     32'(rd_out),    32'(m_rd));
    end
    if (rst) begin
      m_busy = 0; m_done = 0; m_res = '0; m_rd = '0;
    end else if (flush) begin
      m_busy = 0; m_done = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin m_busy = 0; m_done = 1; m_res = m_pend; end
    end else if (start) begin
      m_rd = rd_in;
      if (is_fast(funct3, rs1_data, rs2_data)) begin
        m_done = 1; m_res = ref_op(funct3, rs1_data, rs2_data);
      end else begin
        m_busy = 1; m_left = 32; m_pend = ref_op(funct3, rs1_data, rs2_data);
      end
    end
  end

  task automatic op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                    input int lat, input logic [31:0] expv, input string nm, input bit hold);
    int k = 0;
    int st = 0;
    @(posedge clk); #1;
    start = 1; funct3 = f; rs1_data = a; rs2_data = b; rd_in = rd;
    forever begin
      @(negedge clk);
      if (done || k > 60) break;
      if (stall_req) st++;
      @(posedge clk); #1; k++;
      if (!hold) start = 0;
    end
    chk({nm, "_res"},   result,      expv);
    chk({nm, "_lat"},   32'(k),      32'(lat));
    chk({nm, "_stall"}, 32'(st),     32'(lat));
    chk({nm, "_rd"},    32'(rd_out), 32'(rd));
    if (hold) begin
      chk({nm, "_done_nostall"}, 32'(stall_req), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk({nm, "_reaccept"}, 32'(stall_req), 32'd1);
      @(posedge clk); #1; start = 0;
      repeat (34) @(posedge clk);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      4: return 32'($urandom_range(0, 20));
      5: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; flush = 0; start = 1; funct3 = F3_MUL; rs1_data = 7; rs2_data = 3; rd_in = 5;
    @(posedge clk); #1; chk_en = 1;
    @(negedge clk);
    chk("rst_result", result, 32'h0);
    chk("rst_rd",     32'(rd_out), 32'h0);
    chk("rst_done",   32'(done), 32'h0);
    chk("rst_stall",  32'(stall_req), 32'h0);
    @(posedge clk); #1; rst = 0; start = 0;

    op(F3_MUL,    32'd7,          32'hFFFF_FFFD, 5'd1,  33, 32'hFFFF_FFEB, "mul_7x-3",   0);
    op(F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  33, 32'hFFFF_FFFE, "mulhu_ff",   0);
    op(F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  33, 32'h0000_0000, "mulh_ff",    0);
    op(F3_MULHSU, 32'hFFFF_FFFF,  32'd2,         5'd4,  33, 32'hFFFF_FFFF, "mulhsu_m1x2",0);
    op(F3_DIV,    32'hFFFF_FFF9,  32'd2,         5'd5,  33, 32'hFFFF_FFFD, "div_-7/2",   0);
    op(F3_REM,    32'hFFFF_FFF9,  32'd2,         5'd6,  33, 32'hFFFF_FFFF, "rem_-7/2",   0);
    op(F3_DIVU,   32'd5,          32'd0,         5'd7,  1,  32'hFFFF_FFFF, "divu_5/0",   0);
    op(F3_REMU,   32'd5,          32'd0,         5'd8,  1,  32'd5,         "remu_5/0",   0);
    op(F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd9,  1,  32'h8000_0000, "div_ovf",    0);
    op(F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd10, 1,  32'h0,         "rem_ovf",    0);
    op(F3_DIVU,   32'd100,        32'd7,         5'd11, 33, 32'd14,        "divu_100/7", 0);
    op(F3_REMU,   32'd100,        32'd7,         5'd12, 33, 32'd2,         "remu_100/7", 0);

    // Flush in the tenth CALC cycle.
    @(posedge clk); #1; start = 1; funct3 = F3_MUL; rs1_data = 3; rs2_data = 5; rd_in = 9;
    @(posedge clk); #1; start = 0;
    repeat (9) @(posedge clk);
    #1 flush = 1;
    @(posedge clk); #1 flush = 0;
    @(negedge clk);
    chk("flush_stall",  32'(stall_req), 32'h0);
    chk("flush_done",   32'(done),      32'h0);
    chk("flush_result", result,         32'd2);
    op(F3_MUL, 32'd3, 32'd5, 5'd9, 33, 32'd15, "post_flush", 0);

    // Reset in the twentieth CALC cycle.
    @(posedge clk); #1; start = 1; funct3 = F3_DIVU; rs1_data = 1000; rs2_data = 3; rd_in = 17;
    @(posedge clk); #1; start = 0;
    repeat (19) @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    chk("rstcalc_stall_hi", 32'(stall_req), 32'h0);
    chk("rstcalc_done_hi",  32'(done),      32'h0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rstcalc_result", result,         32'h0);
    chk("rstcalc_rd",     32'(rd_out),    32'h0);
    chk("rstcalc_done",   32'(done),      32'h0);
    chk("rstcalc_stall",  32'(stall_req), 32'h0);

    op(F3_MUL, 32'd6, 32'd7, 5'd3, 33, 32'd42, "hold", 1);

    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      rst      = ($urandom_range(0, 299) == 0);
      flush    = ($urandom_range(0, 99) == 0);
      start    = ($urandom_range(0, 3) != 0);
      funct3   = 3'($urandom_range(0, 7));
      rs1_data = pick();
      rs2_data = pick();
      rd_in    = 5'($urandom);
    end
    @(posedge clk); #1;
    rst = 0; flush = 0; start = 0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
